// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory and keeps instr_if aligned with the address IF/ID holds across stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_sync,
    input  logic             i_stall_n,
    input  logic             i_redirect_valid,
    input  logic [31:0]      i_redirect_target,
    output logic [31:0]      o_imem_addr,
    output logic             o_imem_en,
    input  logic [31:0]      i_imem_rdata,
    output logic [31:0]      o_instr_if,
    output logic [31:0]      o_instr_addr_if,
    output logic             o_misalign_if,
    output logic [CNT_W-1:0] o_fetch_count
);

    logic [31:0]      r_pc;
    logic             r_hold_valid;
    logic [31:0]      r_hold_instr;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_count;

    logic             w_advance;
    logic [31:0]      w_pc_next;

    assign w_advance = i_stall_n | i_redirect_valid;

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect_valid)
            w_pc_next = {i_redirect_target[31:2], 2'b00};
        else if (i_stall_n)
            w_pc_next = r_pc + 32'd4;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_sync) begin
            r_pc          <= RESET_PC;
            r_hold_valid  <= 1'b0;
            r_hold_instr  <= 32'h0;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= i_redirect_valid & (|i_redirect_target[1:0]);

            // Capture once at stall entry so the instruction survives the memory
            // re-reading the held PC; a redirect aborts the stall with no replay.
            if (i_redirect_valid || i_stall_n) begin
                r_hold_valid <= 1'b0;
            end else if (!r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= i_imem_rdata;
            end

            if (w_advance && (r_fetch_count != {CNT_W{1'b1}}))
                r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    assign o_imem_addr     = r_pc;
    assign o_instr_addr_if = r_pc;
    assign o_imem_en       = ~i_rst_sync;
    assign o_instr_if      = r_hold_valid ? r_hold_instr : i_imem_rdata;
    assign o_misalign_if   = r_misalign;
    assign o_fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns 0x1000_0000 + word index.
module tb_if_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_sync, stall_n, redirect_valid;
    logic [31:0]   redirect_target, imem_addr, imem_rdata, instr_if, instr_addr_if;
    logic          imem_en, misalign_if;
    logic [CW-1:0] fetch_count;

    int nvec = 0;
    int nerr = 0;

    if_stage #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_sync(rst_sync), .i_stall_n(stall_n),
        .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
        .o_imem_addr(imem_addr), .o_imem_en(imem_en), .i_imem_rdata(imem_rdata),
        .o_instr_if(instr_if), .o_instr_addr_if(instr_addr_if),
        .o_misalign_if(misalign_if), .o_fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    initial imem_rdata = 32'h0;
    always @(posedge clk)
        if (imem_en) imem_rdata <= 32'h1000_0000 + (imem_addr >> 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_sync = 1'b1; stall_n = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        nvec++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h0); end
        nvec++; if (imem_en !== 1'b0) begin nerr++; $display("FAIL reset_en got %b exp 0", imem_en); end
        nvec++; if (fetch_count !== 4'd0) begin nerr++; $display("FAIL reset_cnt got %0d exp 0", fetch_count); end
        nvec++; if (misalign_if !== 1'b0) begin nerr++; $display("FAIL reset_mis got %b exp 0", misalign_if); end
    endtask

    task automatic test_run();
        rst_sync = 1'b0;
        #1;
        nvec++; if (imem_en !== 1'b1) begin nerr++; $display("FAIL run_en got %b exp 1", imem_en); end
        for (int k = 1; k <= 4; k++) begin
            step();
            nvec++; if (imem_addr !== 32'(4*k)) begin nerr++; $display("FAIL run_addr%0d got %h exp %h", k, imem_addr, 32'(4*k)); end
            nvec++; if (instr_if !== 32'h1000_0000 + 32'(k-1)) begin nerr++; $display("FAIL run_instr%0d got %h exp %h", k, instr_if, 32'h1000_0000 + 32'(k-1)); end
            nvec++; if (fetch_count !== 4'(k)) begin nerr++; $display("FAIL run_cnt%0d got %0d exp %0d", k, fetch_count, k); end
        end
    endtask

    task automatic test_stall();
        stall_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            nvec++; if (imem_addr !== 32'h10) begin nerr++; $display("FAIL stall_addr%0d got %h exp %h", k, imem_addr, 32'h10); end
            nvec++; if (instr_if !== 32'h1000_0003) begin nerr++; $display("FAIL stall_instr%0d got %h exp %h", k, instr_if, 32'h1000_0003); end
            nvec++; if (fetch_count !== 4'd4) begin nerr++; $display("FAIL stall_cnt%0d got %0d exp 4", k, fetch_count); end
        end
        stall_n = 1'b1;
        step();
        nvec++; if (imem_addr !== 32'h14) begin nerr++; $display("FAIL rel_addr got %h exp %h", imem_addr, 32'h14); end
        nvec++; if (instr_if !== 32'h1000_0004) begin nerr++; $display("FAIL rel_instr got %h exp %h", instr_if, 32'h1000_0004); end
        step();
        nvec++; if (instr_if !== 32'h1000_0005) begin nerr++; $display("FAIL rel_instr2 got %h exp %h", instr_if, 32'h1000_0005); end
        nvec++; if (fetch_count !== 4'd6) begin nerr++; $display("FAIL rel_cnt got %0d exp 6", fetch_count); end
    endtask

    task automatic test_redirect_in_stall();
        stall_n = 1'b0;
        step();
        nvec++; if (instr_if !== 32'h1000_0005) begin nerr++; $display("FAIL rs_hold got %h exp %h", instr_if, 32'h1000_0005); end
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
        step();
        nvec++; if (imem_addr !== 32'h200) begin nerr++; $display("FAIL rs_addr got %h exp %h", imem_addr, 32'h200); end
        nvec++; if (misalign_if !== 1'b0) begin nerr++; $display("FAIL rs_mis got %b exp 0", misalign_if); end
        nvec++; if (instr_if !== 32'h1000_0006) begin nerr++; $display("FAIL rs_holdclr got %h exp %h", instr_if, 32'h1000_0006); end
        nvec++; if (fetch_count !== 4'd7) begin nerr++; $display("FAIL rs_cnt got %0d exp 7", fetch_count); end
        redirect_valid = 1'b0; stall_n = 1'b1;
        step();
        nvec++; if (imem_addr !== 32'h204) begin nerr++; $display("FAIL rs_next got %h exp %h", imem_addr, 32'h204); end
        nvec++; if (instr_if !== 32'h1000_0080) begin nerr++; $display("FAIL rs_instr got %h exp %h", instr_if, 32'h1000_0080); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        step();
        nvec++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL mis_addr got %h exp %h", imem_addr, 32'h100); end
        nvec++; if (misalign_if !== 1'b1) begin nerr++; $display("FAIL mis_pulse got %b exp 1", misalign_if); end
        redirect_valid = 1'b0;
        step();
        nvec++; if (misalign_if !== 1'b0) begin nerr++; $display("FAIL mis_clear got %b exp 0", misalign_if); end
        nvec++; if (imem_addr !== 32'h104) begin nerr++; $display("FAIL mis_next got %h exp %h", imem_addr, 32'h104); end
        nvec++; if (fetch_count !== 4'd10) begin nerr++; $display("FAIL mis_cnt got %0d exp 10", fetch_count); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
        step();
        nvec++; if (imem_addr !== 32'hFFFF_FFF8) begin nerr++; $display("FAIL wrap_a0 got %h exp %h", imem_addr, 32'hFFFF_FFF8); end
        redirect_valid = 1'b0;
        step();
        nvec++; if (imem_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_a1 got %h exp %h", imem_addr, 32'hFFFF_FFFC); end
        nvec++; if (instr_if !== 32'h4FFF_FFFE) begin nerr++; $display("FAIL wrap_i1 got %h exp %h", instr_if, 32'h4FFF_FFFE); end
        step();
        nvec++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL wrap_a2 got %h exp %h", imem_addr, 32'h0); end
        nvec++; if (instr_if !== 32'h4FFF_FFFF) begin nerr++; $display("FAIL wrap_i2 got %h exp %h", instr_if, 32'h4FFF_FFFF); end
        nvec++; if (fetch_count !== 4'd13) begin nerr++; $display("FAIL wrap_cnt got %0d exp 13", fetch_count); end
    endtask

    task automatic test_saturate();
        step();
        nvec++; if (fetch_count !== 4'd14) begin nerr++; $display("FAIL sat_14 got %0d exp 14", fetch_count); end
        step();
        nvec++; if (fetch_count !== 4'd15) begin nerr++; $display("FAIL sat_15 got %0d exp 15", fetch_count); end
        step();
        nvec++; if (fetch_count !== 4'd15) begin nerr++; $display("FAIL sat_hold got %0d exp 15", fetch_count); end
        nvec++; if (imem_addr !== 32'hC) begin nerr++; $display("FAIL sat_addr got %h exp %h", imem_addr, 32'hC); end
    endtask

    task automatic test_reset_in_stall();
        stall_n = 1'b0;
        for (int k = 0; k < 3; k++) step();
        nvec++; if (instr_if !== 32'h1000_0002) begin nerr++; $display("FAIL rst_held got %h exp %h", instr_if, 32'h1000_0002); end
        rst_sync = 1'b1;
        step();
        rst_sync = 1'b0;
        #1;
        nvec++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL rst_pc got %h exp %h", imem_addr, 32'h0); end
        nvec++; if (fetch_count !== 4'd0) begin nerr++; $display("FAIL rst_cnt got %0d exp 0", fetch_count); end
        nvec++; if (instr_if !== 32'h1000_0003) begin nerr++; $display("FAIL rst_holdclr got %h exp %h", instr_if, 32'h1000_0003); end
        step();
        nvec++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL rst_stall_pc got %h exp %h", imem_addr, 32'h0); end
        nvec++; if (fetch_count !== 4'd0) begin nerr++; $display("FAIL rst_stall_cnt got %0d exp 0", fetch_count); end
        stall_n = 1'b1;
        step();
        nvec++; if (imem_addr !== 32'h4) begin nerr++; $display("FAIL rst_go_pc got %h exp %h", imem_addr, 32'h4); end
        nvec++; if (instr_if !== 32'h1000_0000) begin nerr++; $display("FAIL rst_go_instr got %h exp %h", instr_if, 32'h1000_0000); end
        nvec++; if (fetch_count !== 4'd1) begin nerr++; $display("FAIL rst_go_cnt got %0d exp 1", fetch_count); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect_in_stall();
        test_misalign();
        test_wrap();
        test_saturate();
        test_reset_in_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
